// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter family.
package i2s_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO: single clock, power-of-2 depth, full/empty/level flags.
module i2s_sample_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Storage is not reset; clearing the count is enough to discard contents.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;

endmodule

// File: rtl/i2s_tx_master.sv
// Master-mode I2S transmitter: generates sck/ws, serialises buffered stereo
// pairs MSB first in Philips I2S or left-justified framing.
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned DIV        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_left,
  input  logic [DW-1:0] in_right,
  output logic          sck,
  output logic          ws,
  output logic          sd,
  output logic          underrun,
  output logic [AW:0]   fifo_level
);

  localparam int unsigned FW  = 2 * SLOT_W;
  localparam int unsigned BW  = $clog2(FW);
  localparam int unsigned DVW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DVW-1:0]     r_div;
  logic               r_sck;
  logic               r_ws;
  logic               r_sd;
  logic               r_underrun;
  logic               r_mode;
  logic [BW-1:0]      r_b;
  logic [FW-1:0]      r_shift;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [2*DW-1:0]    w_dout;
  logic               w_div_wrap;
  logic               w_shift_evt;
  logic               w_load;
  logic               w_mode;
  logic [BW-1:0]      w_b_nxt;
  logic [SLOT_W-1:0]  w_left_slot;
  logic [SLOT_W-1:0]  w_right_slot;
  logic [FW-1:0]      w_frame;
  logic [FW-1:0]      w_shift_nxt;
  logic               w_ws_nxt;
  logic               w_sd_nxt;

  assign w_push = in_valid & ~w_full;

  i2s_sample_fifo #(
    .W     (2 * DW),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_left, in_right}),
    .o_rdata (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_div_wrap  = (r_div == DVW'(DIV - 1));
  assign w_shift_evt = enable & w_div_wrap & r_sck;
  assign w_load      = w_shift_evt & (r_b == '0);
  // Empty is judged before any same-cycle push, so a late push never bypasses.
  assign w_pop       = w_load & ~w_empty;

  // Samples occupy the slot MSBs; unused LSBs are zero.
  assign w_left_slot  = SLOT_W'(w_dout[2*DW-1:DW]) << (SLOT_W - DW);
  assign w_right_slot = SLOT_W'(w_dout[DW-1:0]) << (SLOT_W - DW);

  always_comb begin
    w_b_nxt     = (r_b == BW'(FW - 1)) ? '0 : r_b + BW'(1);
    w_frame     = w_empty ? '0 : {w_left_slot, w_right_slot};
    w_mode      = w_load ? mode : r_mode;
    w_shift_nxt = w_load ? w_frame : {r_shift[FW-2:0], 1'b0};
    if (w_mode == MODE_LJ) begin
      w_ws_nxt = (r_b >= BW'(SLOT_W));
      w_sd_nxt = w_shift_nxt[FW-1];
    end else begin
      // I2S: ws leads by one bit, data lags the LJ stream by one bit.
      w_ws_nxt = (w_b_nxt >= BW'(SLOT_W));
      w_sd_nxt = r_shift[FW-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
      r_mode     <= MODE_I2S;
      r_b        <= '0;
      r_shift    <= '0;
    end else if (!enable) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
      r_b        <= '0;
      r_shift    <= '0;
    end else begin
      r_div      <= w_div_wrap ? '0 : r_div + DVW'(1);
      r_underrun <= w_load & w_empty;
      if (w_div_wrap) r_sck <= ~r_sck;
      if (w_load)     r_mode <= mode;
      if (w_shift_evt) begin
        r_b     <= w_b_nxt;
        r_shift <= w_shift_nxt;
        r_ws    <= w_ws_nxt;
        r_sd    <= w_sd_nxt;
      end
    end
  end

  assign in_ready = ~w_full;
  assign sck      = r_sck;
  assign ws       = r_ws;
  assign sd       = r_sd;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Randomised bench for i2s_tx_master against a bit-stream reference model.
module tb_i2s_tx_master;
  import i2s_pkg::*;

  localparam int unsigned DW       = 16;
  localparam int unsigned SLOT_W   = 32;
  localparam int unsigned DIV      = 2;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AW       = 2;
  localparam int unsigned FW       = 2 * SLOT_W;
  localparam int unsigned BITCLK   = 2 * DIV;
  localparam int unsigned FRAMECLK = FW * BITCLK;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_left;
  logic [DW-1:0] in_right;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          underrun;
  logic [AW:0]   fifo_level;

  i2s_tx_master #(
    .DW         (DW),
    .SLOT_W     (SLOT_W),
    .DIV        (DIV),
    .FIFO_DEPTH (DEPTH),
    .AW         (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model: pairs queue, current frame, cycles since enable.
  logic [2*DW-1:0] q[$];
  logic [2*DW-1:0] m_pair;
  logic            m_mode;
  int              m_cyc;
  logic            exp_sck, exp_ws, exp_sd, exp_ur;
  logic [3:0]      got_pins, exp_pins;

  // Left-justified frame bit k (0..FW-1) of a {left,right} pair.
  function automatic logic lj_bit(input logic [2*DW-1:0] pair, input int k);
    logic [DW-1:0] smp;
    int            idx;
    smp = (k < SLOT_W) ? pair[2*DW-1:DW] : pair[DW-1:0];
    idx = k % SLOT_W;
    return (idx < DW) ? smp[DW-1-idx] : 1'b0;
  endfunction

  // One clk: advance the model with the inputs in force, then settle to negedge.
  task automatic step();
    bit   accept;
    int   k;
    logic last;
    accept = in_valid && (q.size() < DEPTH);
    @(posedge clk);
    exp_ur = 1'b0;
    if (enable) begin
      m_cyc++;
      exp_sck = ((m_cyc / DIV) % 2) == 1;
      if (m_cyc % BITCLK == 0) begin
        k = (m_cyc / BITCLK - 1) % FW;
        if (k == 0) begin
          last   = lj_bit(m_pair, FW - 1);
          m_mode = mode;
          if (q.size() > 0) m_pair = q.pop_front();
          else begin
            m_pair = '0;
            exp_ur = 1'b1;
          end
        end else begin
          last = lj_bit(m_pair, k - 1);
        end
        if (m_mode == MODE_LJ) begin
          exp_sd = lj_bit(m_pair, k);
          exp_ws = (k >= SLOT_W);
        end else begin
          exp_sd = last;
          exp_ws = (((k + 1) % FW) >= SLOT_W);
        end
      end
    end else begin
      m_cyc   = 0;
      m_pair  = '0;
      exp_sck = 1'b0;
      exp_ws  = 1'b0;
      exp_sd  = 1'b0;
    end
    if (accept) q.push_back({in_left, in_right});
    @(negedge clk);
    got_pins = {sck, ws, sd, underrun};
    exp_pins = {exp_sck, exp_ws, exp_sd, exp_ur};
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({sck, ws, sd, underrun} !== 4'b0) begin
      errors++; $display("FAIL reset_pins got=%b exp=0000", {sck, ws, sd, underrun});
    end
    checks++; if (fifo_level !== '0) begin
      errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level);
    end
    checks++; if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
  endtask

  task automatic test_lj_basic();
    mode = MODE_LJ;
    push_pair(16'hA5A5, 16'h5A5A);
    enable = 1'b1;
    for (int c = 0; c < FRAMECLK + 8; c++) begin
      step();
      checks++; if (got_pins !== exp_pins) begin
        errors++; $display("FAIL lj_pins c=%0d got=%b exp=%b", c, got_pins, exp_pins);
      end
      if (c == 1) begin
        checks++; if (sck !== 1'b1) begin
          errors++; $display("FAIL lj_first_rise got=%b exp=1", sck);
        end
      end
      if (c == 3) begin
        checks++; if ({sck, ws, sd} !== 3'b001) begin
          errors++; $display("FAIL lj_first_fall got=%b exp=001", {sck, ws, sd});
        end
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_i2s();
    mode = MODE_I2S;
    push_pair(16'hA5A5, 16'h5A5A);
    enable = 1'b1;
    for (int c = 0; c < FRAMECLK + 8; c++) begin
      step();
      checks++; if (got_pins !== exp_pins) begin
        errors++; $display("FAIL i2s_pins c=%0d got=%b exp=%b", c, got_pins, exp_pins);
      end
      if (c == 3 || c == 7) begin
        checks++; if (sd !== (c == 7)) begin
          errors++; $display("FAIL i2s_delay c=%0d got=%b exp=%b", c, sd, (c == 7));
        end
      end
      if (c == 123 || c == 127) begin
        checks++; if (ws !== (c == 127)) begin
          errors++; $display("FAIL i2s_ws_lead c=%0d got=%b exp=%b", c, ws, (c == 127));
        end
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_underrun();
    int pulses;
    pulses = 0;
    mode   = logic'($urandom_range(0, 1));
    enable = 1'b1;
    for (int c = 0; c < 3 * FRAMECLK; c++) begin
      if (c == 100) begin
        in_valid = 1'b1;
        in_left  = DW'($urandom);
        in_right = DW'($urandom);
      end
      step();
      in_valid = 1'b0;
      if (underrun === 1'b1) pulses++;
      checks++; if (got_pins !== exp_pins) begin
        errors++; $display("FAIL ur_pins c=%0d got=%b exp=%b", c, got_pins, exp_pins);
      end
    end
    checks++; if (pulses != 2) begin
      errors++; $display("FAIL ur_count got=%0d exp=2", pulses);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_fifo_full();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_left  = DW'($urandom);
      in_right = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got=%0d/%b exp=4/0", fifo_level, in_ready);
    end
    mode   = logic'($urandom_range(0, 1));
    enable = 1'b1;
    for (int c = 0; c < 4 * FRAMECLK + 8; c++) begin
      step();
      checks++; if (got_pins !== exp_pins || fifo_level !== q.size()
                    || in_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL full_drain c=%0d got=%b/%0d/%b exp=%b/%0d/%b", c, got_pins,
                           fifo_level, in_ready, exp_pins, q.size(), (q.size() < DEPTH));
      end
      if (c == 3) begin
        checks++; if (fifo_level !== 3'd3 || in_ready !== 1'b1) begin
          errors++; $display("FAIL full_first_pop got=%0d/%b exp=3/1", fifo_level, in_ready);
        end
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_abort();
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    mode   = logic'($urandom_range(0, 1));
    enable = 1'b1;
    for (int c = 0; c < 3 + 4 * 10 + 1; c++) begin
      step();
      checks++; if (got_pins !== exp_pins) begin
        errors++; $display("FAIL abort_pre c=%0d got=%b exp=%b", c, got_pins, exp_pins);
      end
    end
    enable = 1'b0;
    step();
    checks++; if ({sck, ws, sd, underrun} !== 4'b0 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL abort_stop got=%b/%0d exp=0000/1", {sck, ws, sd, underrun},
                         fifo_level);
    end
    enable = 1'b1;
    for (int c = 0; c < FRAMECLK + 8; c++) begin
      step();
      checks++; if (got_pins !== exp_pins) begin
        errors++; $display("FAIL abort_resume c=%0d got=%b exp=%b", c, got_pins, exp_pins);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_random();
    int drop_at;
    for (int it = 0; it < 3; it++) begin
      mode    = logic'($urandom_range(0, 1));
      drop_at = $urandom_range(50, 2 * FRAMECLK - 50);
      enable  = 1'b1;
      for (int c = 0; c < 2 * FRAMECLK; c++) begin
        in_valid = ($urandom_range(0, 99) < 2);
        in_left  = DW'($urandom);
        in_right = DW'($urandom);
        if (c == FRAMECLK / 2) mode = logic'($urandom_range(0, 1));
        enable = !(c >= drop_at && c < drop_at + 3);
        step();
        checks++; if (got_pins !== exp_pins || fifo_level !== q.size()) begin
          errors++; $display("FAIL rand it=%0d c=%0d got=%b/%0d exp=%b/%0d", it, c, got_pins,
                             fifo_level, exp_pins, q.size());
        end
      end
      in_valid = 1'b0;
      enable   = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    enable = 1'b1;
    repeat (30) step();
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({sck, ws, sd, underrun} !== 4'b0 || fifo_level !== '0 || in_ready !== 1'b1)
    begin
      errors++; $display("FAIL reset_mid got=%b/%0d/%b exp=0000/0/1", {sck, ws, sd, underrun},
                         fifo_level, in_ready);
    end
    enable = 1'b0;
    q.delete();
    @(negedge clk) reset_n = 1'b1;
    step();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset_n  = 1'b1;
    enable   = 1'b0;
    mode     = MODE_I2S;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    m_cyc    = 0;
    m_pair   = '0;
    m_mode   = MODE_I2S;
    exp_sck  = 1'b0;
    exp_ws   = 1'b0;
    exp_sd   = 1'b0;
    exp_ur   = 1'b0;
    test_reset();
    test_lj_basic();
    test_i2s();
    test_underrun();
    test_fifo_full();
    test_abort();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
